// File: rtl/picorv_pcpi_pkg.sv
// Shared decode constants, funct3/state encodings and operand-signedness helpers
// for the PCPI sequential multiplier.
package picorv_pcpi_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } mul_state_e;

    // funct3 values 000..011 are the multiplies; 1xx are divide/remainder.
    function automatic logic is_mul_insn(input logic [6:0] opcode,
                                         input logic [6:0] funct7,
                                         input logic       funct3_msb);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && !funct3_msb;
    endfunction

    function automatic logic rs1_is_signed(input mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input mul_op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/pcpi_mul_step.sv
// Combinational shift-add block retiring STEPS_AT_ONCE multiplier bits,
// all arithmetic modulo 2^64.
module pcpi_mul_step #(
    parameter int STEPS_AT_ONCE = 1
) (
    input  logic [63:0] acc_in,
    input  logic [63:0] rs1_in,
    input  logic [63:0] rs2_in,
    output logic [63:0] acc_out,
    output logic [63:0] rs1_out,
    output logic [63:0] rs2_out
);

    logic [63:0] acc_chain [0:STEPS_AT_ONCE];
    logic [63:0] rs1_chain [0:STEPS_AT_ONCE];
    logic [63:0] rs2_chain [0:STEPS_AT_ONCE];

    assign acc_chain[0] = acc_in;
    assign rs1_chain[0] = rs1_in;
    assign rs2_chain[0] = rs2_in;

    genvar gi;
    generate
        for (gi = 0; gi < STEPS_AT_ONCE; gi++) begin : g_step
            assign acc_chain[gi+1] = rs2_chain[gi][0] ? (acc_chain[gi] + rs1_chain[gi])
                                                      : acc_chain[gi];
            assign rs1_chain[gi+1] = rs1_chain[gi] << 1;
            assign rs2_chain[gi+1] = rs2_chain[gi] >> 1;
        end
    endgenerate

    assign acc_out = acc_chain[STEPS_AT_ONCE];
    assign rs1_out = rs1_chain[STEPS_AT_ONCE];
    assign rs2_out = rs2_chain[STEPS_AT_ONCE];

endmodule

// File: rtl/pcpi_mul_seq.sv
// Sequential RV32M multiply coprocessor on the PicoRV32 PCPI port.
// Optional build macro PCPI_MUL_ABORT_EN: dropping pcpi_valid during BUSY abandons the op.
module pcpi_mul_seq
    import picorv_pcpi_pkg::*;
#(
    parameter int STEPS_AT_ONCE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    localparam int         N        = 64 / STEPS_AT_ONCE;
    localparam logic [5:0] CNT_INIT = 6'(N - 1);

    mul_state_e  state_reg, state_next;
    mul_op_e     op_reg, op_next;
    logic [63:0] acc_reg, acc_next;
    logic [63:0] rs1_reg, rs1_next;
    logic [63:0] rs2_reg, rs2_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] rd_reg, rd_next;
    logic        wait_reg, ready_reg, wr_reg;

    logic [63:0] acc_step, rs1_step, rs2_step;
    logic        insn_hit;
    logic        abort;
    mul_op_e     op_decoded;

    // Register fields and immediate bits never influence a multiply.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign insn_hit   = is_mul_insn(pcpi_insn[6:0], pcpi_insn[31:25], pcpi_insn[14]);
    assign op_decoded = mul_op_e'(pcpi_insn[14:12]);

`ifdef PCPI_MUL_ABORT_EN
    assign abort = !pcpi_valid;
`else
    assign abort = 1'b0;
`endif

    pcpi_mul_step #(
        .STEPS_AT_ONCE(STEPS_AT_ONCE)
    ) u_step (
        .acc_in (acc_reg),
        .rs1_in (rs1_reg),
        .rs2_in (rs2_reg),
        .acc_out(acc_step),
        .rs1_out(rs1_step),
        .rs2_out(rs2_step)
    );

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        acc_next   = acc_reg;
        rs1_next   = rs1_reg;
        rs2_next   = rs2_reg;
        cnt_next   = cnt_reg;
        rd_next    = rd_reg;

        case (state_reg)
            IDLE: begin
                if (pcpi_valid && insn_hit) begin
                    state_next = BUSY;
                    op_next    = op_decoded;
                    rs1_next   = rs1_is_signed(op_decoded) ? {{32{pcpi_rs1[31]}}, pcpi_rs1}
                                                           : {32'd0, pcpi_rs1};
                    rs2_next   = rs2_is_signed(op_decoded) ? {{32{pcpi_rs2[31]}}, pcpi_rs2}
                                                           : {32'd0, pcpi_rs2};
                    acc_next   = 64'd0;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    acc_next = acc_step;
                    rs1_next = rs1_step;
                    rs2_next = rs2_step;
                    cnt_next = cnt_reg - 6'd1;
                    if (cnt_reg == 6'd0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The result is captured on the final step so it is stable for the whole DONE cycle.
        if (state_reg == BUSY && state_next == DONE) begin
            rd_next = (op_reg == MUL) ? acc_next[31:0] : acc_next[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= MUL;
            acc_reg   <= 64'd0;
            rs1_reg   <= 64'd0;
            rs2_reg   <= 64'd0;
            cnt_reg   <= 6'd0;
            rd_reg    <= 32'd0;
            wait_reg  <= 1'b0;
            ready_reg <= 1'b0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            acc_reg   <= acc_next;
            rs1_reg   <= rs1_next;
            rs2_reg   <= rs2_next;
            cnt_reg   <= cnt_next;
            rd_reg    <= rd_next;
            wait_reg  <= (state_next == BUSY);
            ready_reg <= (state_next == DONE);
            wr_reg    <= (state_next == DONE);
        end
    end

    assign pcpi_wait  = wait_reg;
    assign pcpi_ready = ready_reg;
    assign pcpi_wr    = wr_reg;
    assign pcpi_rd    = rd_reg;

endmodule

// File: tb/tb_pcpi_mul_seq.sv
// Scoreboard bench for pcpi_mul_seq: one instance with 1 step/cycle and one with 8.
module tb_pcpi_mul_seq;

    localparam logic [6:0] OPC    = 7'b0110011;
    localparam logic [6:0] F7_M   = 7'b0000001;
    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [2:0] F3_MH  = 3'b001;
    localparam logic [2:0] F3_MHSU = 3'b010;
    localparam logic [2:0] F3_MHU = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;

    logic        wr1, ready1, wait1;
    logic [31:0] rd1;
    logic        wr8, ready8, wait8;
    logic [31:0] rd8;

    logic        sel8 = 1'b0;
    int          n_cur = 64;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];

    logic        wr_m, ready_m, wait_m;
    logic [31:0] rd_m;
    assign wr_m    = sel8 ? wr8 : wr1;
    assign ready_m = sel8 ? ready8 : ready1;
    assign wait_m  = sel8 ? wait8 : wait1;
    assign rd_m    = sel8 ? rd8 : rd1;

    always #5 clk = ~clk;

    pcpi_mul_seq #(.STEPS_AT_ONCE(1)) dut1 (
        .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr1), .pcpi_rd(rd1),
        .pcpi_wait(wait1), .pcpi_ready(ready1)
    );

    pcpi_mul_seq #(.STEPS_AT_ONCE(8)) dut8 (
        .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr8), .pcpi_rd(rd8),
        .pcpi_wait(wait8), .pcpi_ready(ready8)
    );

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Reference via signed/unsigned 64-bit products.
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            F3_MH:   p = 64'(sa * sb);
            F3_MHSU: p = 64'(sa * longint'({32'd0, b}));
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (f3 == F3_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        pcpi_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_rd, input int hold, input string tag);
        logic [31:0] insn_w, got, e;
        int          ready_cyc;
        bit          prof_ok;
        insn_w = mk_insn(F7_M, f3, OPC);
        exp_q.push_back(exp_rd);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn_w;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        ready_cyc  = 0;
        prof_ok    = 1'b1;
        got        = 32'd0;
        for (int c = 1; c <= n_cur + 6 && ready_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                pcpi_insn = mk_insn(7'h00, 3'b000, OPC);
                pcpi_rs1  = ~a;
                pcpi_rs2  = $urandom;
            end
            if (wait_m !== 1'(c <= n_cur)) prof_ok = 1'b0;
            if (wr_m !== ready_m) prof_ok = 1'b0;
            if (ready_m === 1'b1) begin
                ready_cyc = c;
                got = rd_m;
            end
        end
        e = exp_q.pop_front();
        $display("op %s f3=%0d rs1=%h rs2=%h rd=%h exp=%h ready_cycle=%0d",
                 tag, f3, a, b, got, e, ready_cyc);
        total++;
        if (ready_cyc != n_cur + 1) begin
            bad++;
            $display("FAIL %s latency: ready at cycle %0d, want %0d", tag, ready_cyc, n_cur + 1);
        end
        total++;
        if (!prof_ok) begin
            bad++;
            $display("FAIL %s wait/wr profile: wait not high exactly cycles 1..%0d or wr!=ready", tag, n_cur);
        end
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s result: got %h want %h", tag, got, e);
        end
        if (hold > 0) pcpi_insn = insn_w;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total++;
            if (ready_m !== 1'b0 || wait_m !== 1'b0) begin
                bad++;
                $display("FAIL %s hold reclaim: wait=%b ready=%b want 0 0", tag, wait_m, ready_m);
            end
        end
        pcpi_valid = 1'b0;
        @(negedge clk);
        total++;
        if (ready_m !== 1'b0 || wr_m !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse width: ready=%b wr=%b after pulse, want 0 0", tag, ready_m, wr_m);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (wait1 !== 1'b0) begin bad++; $display("FAIL reset wait: got %b want 0", wait1); end
        total++;
        if (ready1 !== 1'b0) begin bad++; $display("FAIL reset ready: got %b want 0", ready1); end
        total++;
        if (wr1 !== 1'b0) begin bad++; $display("FAIL reset wr: got %b want 0", wr1); end
        total++;
        if (rd1 !== 32'd0) begin bad++; $display("FAIL reset rd: got %h want 0", rd1); end
        total++;
        if ({wait8, ready8, wr8} !== 3'b000 || rd8 !== 32'd0) begin
            bad++;
            $display("FAIL reset dut8: wait/ready/wr=%b rd=%h want 000 0", {wait8, ready8, wr8}, rd8);
        end
    endtask

    task automatic test_ignore_non_mul();
        logic [31:0] list [5];
        bit          seen;
        list[0] = mk_insn(7'h00, 3'b000, OPC);
        list[1] = mk_insn(F7_M, 3'b100, OPC);
        list[2] = mk_insn(F7_M, 3'b110, OPC);
        list[3] = mk_insn(F7_M, 3'b000, 7'b0010011);
        list[4] = mk_insn(7'b0100000, 3'b000, OPC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pcpi_valid = 1'b1;
            pcpi_insn  = list[i];
            pcpi_rs1   = 32'd9;
            pcpi_rs2   = 32'd11;
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if ({wait1, ready1, wr1, wait8, ready8, wr8} !== 6'd0) seen = 1'b1;
            end
            pcpi_valid = 1'b0;
            $display("ignore insn=%h claimed=%b", list[i], seen);
            total++;
            if (seen) begin bad++; $display("FAIL ignore insn %h: claimed=1 want 0", list[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        run_op(F3_MUL, 32'd7, 32'd6, 32'd42, 0, "mul_7x6");
    endtask

    task automatic test_mulh();
        run_op(F3_MH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
        run_op(F3_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0, "mul_min");
    endtask

    task automatic test_mulhsu_mulhu();
        run_op(F3_MHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ones");
        run_op(F3_MHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_ones");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            f3 = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            run_op(f3, a, b, ref_mul(f3, a, b), 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(F3_MUL, 32'd1000, 32'd3000, 32'd3000000, 2, "b2b_first");
        run_op(F3_MH, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFF, 0, "b2b_second");
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(F7_M, F3_MUL, OPC);
        pcpi_rs1   = 32'd100;
        pcpi_rs2   = 32'd200;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 30) begin
                reset = 1'b1;
                pcpi_valid = 1'b0;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset_mid_op wait=%b ready=%b wr=%b rd=%h", wait1, ready1, wr1, rd1);
        total++;
        if ({wait1, ready1, wr1} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid flags: wait/ready/wr=%b want 000", {wait1, ready1, wr1});
        end
        total++;
        if (rd1 !== 32'd0) begin bad++; $display("FAIL reset_mid rd: got %h want 0", rd1); end
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ready1 !== 1'b0 || wait1 !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL reset_mid stale ready: seen=1 want 0"); end
        run_op(F3_MUL, 32'd3, 32'd5, 32'd15, 0, "mul_after_reset");
    endtask

    task automatic test_abort();
        logic [31:0] a, b;
        bit          saw_ready, wait_at10, wait_at11;
        int          ready_cyc;
        logic [31:0] got, e;
        a = 32'd1234;
        b = 32'd5678;
        exp_q.push_back(ref_mul(F3_MUL, a, b));
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(F7_M, F3_MUL, OPC);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        saw_ready = 1'b0;
        wait_at10 = 1'b0;
        wait_at11 = 1'b1;
        ready_cyc = 0;
        got = 32'd0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 10) wait_at10 = wait1;
            if (c == 11) wait_at11 = wait1;
            if (ready1 === 1'b1) begin
                saw_ready = 1'b1;
                ready_cyc = c;
                got = rd1;
            end
            if (c == 10) pcpi_valid = 1'b0;
        end
        e = exp_q.pop_front();
        $display("abort_stim wait10=%b wait11=%b ready_cycle=%0d rd=%h", wait_at10, wait_at11, ready_cyc, got);
        total++;
        if (wait_at10 !== 1'b1) begin bad++; $display("FAIL abort wait@10: got %b want 1", wait_at10); end
`ifdef PCPI_MUL_ABORT_EN
        total++;
        if (wait_at11 !== 1'b0) begin bad++; $display("FAIL abort wait@11: got %b want 0", wait_at11); end
        total++;
        if (saw_ready) begin bad++; $display("FAIL abort ready: pulse at %0d want none", ready_cyc); end
`else
        total++;
        if (wait_at11 !== 1'b1) begin bad++; $display("FAIL noabort wait@11: got %b want 1", wait_at11); end
        total++;
        if (ready_cyc != 65) begin bad++; $display("FAIL noabort latency: got %0d want 65", ready_cyc); end
        total++;
        if (got !== e) begin bad++; $display("FAIL noabort result: got %h want %h", got, e); end
`endif
    endtask

    task automatic test_steps8();
        do_reset();
        sel8  = 1'b1;
        n_cur = 8;
        run_op(F3_MHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "s8_mulhu");
        run_op(F3_MH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "s8_mulh");
        run_op(F3_MHSU, 32'hFFFF_FFF0, 32'd17, ref_mul(F3_MHSU, 32'hFFFF_FFF0, 32'd17), 0, "s8_mulhsu");
        sel8  = 1'b0;
        n_cur = 64;
    endtask

    initial begin
        reset      = 1'b1;
        pcpi_valid = 1'b0;
        pcpi_insn  = 32'd0;
        pcpi_rs1   = 32'd0;
        pcpi_rs2   = 32'd0;
        test_reset();
        test_ignore_non_mul();
        test_mul_basic();
        test_mulh();
        test_mulhsu_mulhu();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        test_abort();
        test_steps8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcpi_mul_seq.md
Name: pcpi_mul_seq

Overview:
Sequential multiply coprocessor on the PicoRV32 PCPI port, directly downstream of the core's pcpi_intf bundle. Claims RV32M MUL/MULH/MULHSU/MULHU, computes by iterative shift-add and returns the result through the PCPI ready/wr handshake. Standalone replacement for the core's internal multiplier, verified through pcpi_intf.

Parameters:
STEPS_AT_ONCE, 1, multiplier bits retired per BUSY cycle; legal 1,2,4,8,16,32,64; BUSY length N = 64/STEPS_AT_ONCE.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
pcpi_valid  input  1  core presents instruction
pcpi_insn  input  32  instruction word
pcpi_rs1  input  32  operand rs1
pcpi_rs2  input  32  operand rs2
pcpi_wr  output  1  write pcpi_rd to rd; pulses with pcpi_ready
pcpi_rd  output  32  result
pcpi_wait  output  1  instruction claimed, result pending
pcpi_ready  output  1  result valid, single-cycle pulse

Behaviour:
- Interface: one clock (clk), reset synchronous active-high (reset).
- Reset: state=IDLE; pcpi_wr, pcpi_ready, pcpi_wait = 0; pcpi_rd = 0; internal regs cleared. Reset mid-BUSY/DONE: all outputs 0 on the next cycle, no ready pulse for the aborted op.
- Decode hit: insn[6:0]=7'b0110011, insn[31:25]=7'b0000001, insn[14:12] in {000 MUL, 001 MULH, 010 MULHSU, 011 MULHU}. Any other insn is ignored: no wait, no ready, ever.
- States: IDLE, BUSY, DONE, HOLD.
- IDLE -> BUSY when pcpi_valid && hit. Latch funct3. Operands extend to 64 bits: rs1 signed for MULH/MULHSU; rs2 signed for MULH only; otherwise zero-extended. acc=0, cnt=N-1.
- BUSY: repeat STEPS_AT_ONCE times per cycle: if rs2_reg[0] then acc += rs1_reg; rs1_reg <<= 1; rs2_reg >>= 1. All arithmetic is modulo 2^64. cnt decrements. BUSY -> DONE when cnt==0.
- DONE (1 cycle): pcpi_ready=1, pcpi_wr=1. pcpi_rd = acc[31:0] for MUL, else acc[63:32]. Next state HOLD.
- HOLD (1 cycle): acceptance suppressed. The core drops pcpi_valid after ready, so this prevents re-claiming the same instruction. Next state IDLE.
- Outputs are registered. pcpi_wait = (state==BUSY). pcpi_rd holds its last value outside DONE; only DONE qualifies it.
- Latency: valid+hit sampled at cycle 0 -> wait high cycles 1..N -> ready/wr at cycle N+1. STEPS_AT_ONCE=1 gives ready at cycle 65. wait first rises at cycle 1, well inside the core's 16-cycle PCPI timeout.
- pcpi_insn, rs1 and rs2 changes after acceptance are ignored. Operands are latched.

Optional Feature:
PCPI_MUL_ABORT_EN
- Defined: pcpi_valid low during BUSY -> IDLE next cycle, wait drops, no ready/wr pulse.
- Undefined: the operation runs to completion and issues the ready/wr pulse regardless of pcpi_valid.

Decomposition:
- Package picorv_pcpi_pkg holds:
  - OPCODE_OP and FUNCT7_MULDIV constants
  - funct3 enum mul_op_e (MUL, MULH, MULHSU, MULHU)
  - state enum mul_state_e (IDLE, BUSY, DONE, HOLD)
- Sub-module pcpi_mul_step: combinational STEPS_AT_ONCE-deep shift-add on (acc, rs1_reg, rs2_reg). It isolates the only parameterised datapath and is instantiated once.

Test Plan:
- MUL rs1=7, rs2=6, STEPS_AT_ONCE=1 -> wait cycles 1..64, ready=wr=1 at cycle 65 only, pcpi_rd=42.
- MULH rs1=0x80000000, rs2=0x80000000 -> pcpi_rd=0x40000000; MUL same operands -> 0x00000000.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE; STEPS_AT_ONCE=8 -> ready at cycle 9.
- ADD insn (funct7=0) held valid 20 cycles -> wait, ready, wr stay 0 throughout. Back-to-back MULs with valid dropped one cycle after ready -> second op accepted; no duplicate claim in HOLD.
- reset=1 at cycle 30 of a MUL -> cycle 31: all outputs 0, state IDLE; no ready afterwards. New MUL 3*5 after reset -> 15.
- PCPI_MUL_ABORT_EN defined, pcpi_valid low at cycle 10 -> wait low from cycle 11, no ready pulse. Macro undefined, same stimulus -> ready at cycle 65 with correct pcpi_rd.
